if_fetch_buffer: RTL

- Fetch-side stage directly downstream of the PC register.
- Takes PCF, issues single-outstanding requests to instruction memory, and queues returned instructions with their PC and PC+4 for the decode stage.
- Drives StallF back to the PC register and absorbs branch flushes, including dropping in-flight memory responses.

---
 rtl/if_fetch_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_fetch_buffer.sv
// Fetch buffer between the PC register and decode: single-outstanding imem requests, a circular
// instruction queue, and flush handling. Define IF_FETCH_PERF_EN to add FetchCnt/DropCnt counters.
module if_fetch_buffer #(
   parameter int          DEPTH         = 4,
   parameter logic [31:0] RESET_PC_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   output logic        StallF,
   input  logic        FlushD,
   input  logic        StallD,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemRdata,
   output logic        ValidD,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] FetchCnt,
   output logic [31:0] DropCnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t          state;
   logic [31:0]     addr_q;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc_mem    [DEPTH];

   logic issue;
   logic push;
   logic pop;

   assign issue = (state == IDLE) && (count < CW'(DEPTH)) && !FlushD;
   assign push  = !rst && (state == WAIT) && ImemAck && !FlushD;
   assign pop   = ValidD && !StallD && !FlushD;

   // StallF drops in every flush cycle so a redirect always reaches the PC register.
   always_comb begin
      ImemReq  = 1'b0;
      ImemAddr = '0;
      StallF   = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               ImemReq  = issue;
               ImemAddr = issue ? PCF : '0;
               StallF   = !FlushD;
            end
            WAIT: begin
               ImemReq  = 1'b1;
               ImemAddr = addr_q;
               StallF   = !ImemAck && !FlushD;
            end
            DROP: begin
               ImemReq  = 1'b1;
               ImemAddr = addr_q;
               StallF   = !FlushD;
            end
            default: ;
         endcase
      end
   end

   assign ValidD   = !rst && (count != '0);
   assign InstrD   = ValidD ? instr_mem[rd_ptr] : RESET_PC_WORD;
   assign PCD      = ValidD ? pc_mem[rd_ptr] : '0;
   assign PCPlus4D = ValidD ? pc_mem[rd_ptr] + 32'd4 : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         unique case (state)
            IDLE: if (issue) begin
               addr_q <= PCF;
               state  <= WAIT;
            end
            WAIT: begin
               if (ImemAck)     state <= IDLE;
               else if (FlushD) state <= DROP;
            end
            DROP: if (ImemAck) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (FlushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
         end
      end
   end

   // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= ImemRdata;
         pc_mem[wr_ptr]    <= addr_q;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic drop_ack;
   assign drop_ack = ((state == WAIT) && ImemAck && FlushD) || ((state == DROP) && ImemAck);

   always_ff @(posedge clk) begin
      if (rst) begin
         FetchCnt <= '0;
         DropCnt  <= '0;
      end else begin
         if (push)     FetchCnt <= FetchCnt + 32'd1;
         if (drop_ack) DropCnt  <= DropCnt + 32'd1;
      end
   end
`endif

endmodule
